// File: rtl/coloram_arb.sv
// Colour RAM arbiter: shares one RAM port between video lookups, posted CPU writes,
// CPU reads and a hardware clear sweep. Video always wins and has a fixed 3-cycle latency.
module coloram_arb #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] CLR_VALUE  = 8'h00
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       vid_rd_n,
   input  logic [7:0] vid_a,
   output logic [7:0] vid_do,
   output logic       vid_valid,
   input  logic [7:0] cpu_a,
   input  logic [7:0] cpu_di,
   input  logic       cpu_w_n,
   input  logic       cpu_r_n,
   output logic [7:0] cpu_do,
   output logic       cpu_rd_valid,
   output logic       cpu_wait,
   output logic       wr_drop,
   input  logic       clr_req,
   output logic       clr_busy,
   output logic [7:0] ram_a,
   output logic [7:0] ram_di,
   output logic       ram_w_n,
   output logic       ram_r_n,
   input  logic [7:0] ram_do
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RD_DRAIN,
      S_RD_ISSUE,
      S_RD_WAIT
   } state_t;

   state_t        r_state;
   logic [7:0]    r_clr_cnt;
   logic [7:0]    r_rd_a;
   logic [7:0]    r_q_a [FIFO_DEPTH];
   logic [7:0]    r_q_d [FIFO_DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_cnt;
   logic          r_vid_vld_p1, r_vid_vld_p2;
   logic          r_cpu_vld_p1, r_cpu_vld_p2;

   logic w_vid, w_full, w_empty, w_push, w_pop, w_clr_g, w_rd_g;

   // Grant priority: video, sweep write, queue head, CPU read.
   assign w_vid    = ~vid_rd_n;
   assign w_full   = (r_cnt == (AW+1)'(FIFO_DEPTH));
   assign w_empty  = (r_cnt == '0);
   assign w_push   = ~cpu_w_n & ~w_full;
   assign w_clr_g  = ~w_vid & (r_state == S_CLEAR);
   assign w_pop    = ~w_vid & (r_state != S_CLEAR) & ~w_empty;
   assign w_rd_g   = ~w_vid & ~w_pop & (r_state == S_RD_ISSUE);

   assign clr_busy = (r_state == S_CLEAR);
   assign cpu_wait = w_full | (r_state == S_RD_DRAIN) | (r_state == S_RD_ISSUE) |
                     (r_state == S_RD_WAIT);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_a[r_wp] <= cpu_a;
         r_q_d[r_wp] <= cpu_di;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_clr_cnt    <= '0;
         r_rd_a       <= '0;
         r_wp         <= '0;
         r_rp         <= '0;
         r_cnt        <= '0;
         r_vid_vld_p1 <= 1'b0;
         r_vid_vld_p2 <= 1'b0;
         r_cpu_vld_p1 <= 1'b0;
         r_cpu_vld_p2 <= 1'b0;
         ram_a        <= '0;
         ram_di       <= '0;
         ram_w_n      <= 1'b1;
         ram_r_n      <= 1'b1;
         vid_do       <= '0;
         vid_valid    <= 1'b0;
         cpu_do       <= '0;
         cpu_rd_valid <= 1'b0;
         wr_drop      <= 1'b0;
      end else begin
         // p0: grant cycle drives the RAM port registers
         ram_w_n <= 1'b1;
         ram_r_n <= 1'b1;
         if (w_vid) begin
            ram_a   <= vid_a;
            ram_r_n <= 1'b0;
         end else if (w_clr_g) begin
            ram_a   <= r_clr_cnt;
            ram_di  <= CLR_VALUE;
            ram_w_n <= 1'b0;
         end else if (w_pop) begin
            ram_a   <= r_q_a[r_rp];
            ram_di  <= r_q_d[r_rp];
            ram_w_n <= 1'b0;
         end else if (w_rd_g) begin
            ram_a   <= r_rd_a;
            ram_r_n <= 1'b0;
         end

         // p1: RAM samples the op; p2: ram_do valid and captured
         r_vid_vld_p1 <= w_vid;
         r_vid_vld_p2 <= r_vid_vld_p1;
         vid_valid    <= r_vid_vld_p2;
         if (r_vid_vld_p2) vid_do <= ram_do;

         r_cpu_vld_p1 <= w_rd_g;
         r_cpu_vld_p2 <= r_cpu_vld_p1;
         cpu_rd_valid <= r_cpu_vld_p2;
         if (r_cpu_vld_p2) cpu_do <= ram_do;

         wr_drop <= ~cpu_w_n & w_full;

         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);

         case (r_state)
            S_IDLE: begin
               if (clr_req) begin
                  r_state <= S_CLEAR;
               end else if (!cpu_r_n) begin
                  r_rd_a  <= cpu_a;
                  r_state <= S_RD_DRAIN;
               end
            end
            S_CLEAR: begin
               if (w_clr_g) begin
                  r_clr_cnt <= r_clr_cnt + 8'd1;
                  if (r_clr_cnt == 8'hFF) r_state <= S_IDLE;
               end
            end
            S_RD_DRAIN: if (w_empty) r_state <= S_RD_ISSUE;
            S_RD_ISSUE: if (w_rd_g) r_state <= S_RD_WAIT;
            S_RD_WAIT:  if (r_cpu_vld_p2) r_state <= S_IDLE;
            default:    r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_coloram_arb.sv
// Bench for coloram_arb: synchronous RAM model, reference memory image and a
// strobe-to-data video model checked every cycle, plus directed scenarios.
module tb_coloram_arb;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       vid_rd_n = 1'b1;
   logic [7:0] vid_a = '0;
   logic [7:0] vid_do;
   logic       vid_valid;
   logic [7:0] cpu_a = '0;
   logic [7:0] cpu_di = '0;
   logic       cpu_w_n = 1'b1;
   logic       cpu_r_n = 1'b1;
   logic [7:0] cpu_do;
   logic       cpu_rd_valid;
   logic       cpu_wait;
   logic       wr_drop;
   logic       clr_req = 1'b0;
   logic       clr_busy;
   logic [7:0] ram_a;
   logic [7:0] ram_di;
   logic       ram_w_n;
   logic       ram_r_n;
   logic [7:0] ram_do;

   always #5 clk = ~clk;

   coloram_arb #(.FIFO_DEPTH(DEPTH), .CLR_VALUE(8'h00)) dut (
      .clk(clk), .reset_n(reset_n),
      .vid_rd_n(vid_rd_n), .vid_a(vid_a), .vid_do(vid_do), .vid_valid(vid_valid),
      .cpu_a(cpu_a), .cpu_di(cpu_di), .cpu_w_n(cpu_w_n), .cpu_r_n(cpu_r_n),
      .cpu_do(cpu_do), .cpu_rd_valid(cpu_rd_valid), .cpu_wait(cpu_wait),
      .wr_drop(wr_drop), .clr_req(clr_req), .clr_busy(clr_busy),
      .ram_a(ram_a), .ram_di(ram_di), .ram_w_n(ram_w_n), .ram_r_n(ram_r_n),
      .ram_do(ram_do)
   );

   // Colour RAM: one op per edge, read data appears the cycle after sampling.
   logic [7:0] mem [256];
   logic       preload = 1'b0;
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
      end else begin
         if (!ram_w_n) mem[ram_a] <= ram_di;
         if (!ram_r_n) ram_do <= mem[ram_a];
      end
   end

   int n_chk = 0;
   int n_pass = 0;
   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference image and video model: a strobe returns its image data 3 cycles later.
   logic [7:0] exp_mem [256];
   logic [2:0] vp_v;
   logic [7:0] vp_d0, vp_d1, vp_d2;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vp_v <= '0;
      end else begin
         vp_v  <= {vp_v[1:0], ~vid_rd_n};
         vp_d0 <= exp_mem[vid_a];
         vp_d1 <= vp_d0;
         vp_d2 <= vp_d1;
      end
   end

   logic [7:0] cap [16];
   int cap_n = 0;
   always @(negedge clk) begin
      if (reset_n) begin
         check("vid_valid", vid_valid, vp_v[2]);
         if (vp_v[2]) check("vid_do", vid_do, vp_d2);
         if (vid_valid && cap_n < 16) begin
            cap[cap_n] = vid_do;
            cap_n++;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_ram_w_n"}, ram_w_n, 1);
      check({tag, "_ram_r_n"}, ram_r_n, 1);
      check({tag, "_ram_a"}, ram_a, 0);
      check({tag, "_ram_di"}, ram_di, 0);
      check({tag, "_vid_do"}, vid_do, 0);
      check({tag, "_cpu_do"}, cpu_do, 0);
      check({tag, "_vid_valid"}, vid_valid, 0);
      check({tag, "_cpu_rd_valid"}, cpu_rd_valid, 0);
      check({tag, "_wr_drop"}, wr_drop, 0);
      check({tag, "_clr_busy"}, clr_busy, 0);
      check({tag, "_cpu_wait"}, cpu_wait, 0);
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      cpu_w_n = 1'b0;
      cpu_a = a;
      cpu_di = d;
      exp_mem[a] = d;
      tick();
      cpu_w_n = 1'b1;
   endtask

   task automatic do_read(input logic [7:0] a, input logic [7:0] e, input string tag);
      int got;
      got = 0;
      cpu_r_n = 1'b0;
      cpu_a = a;
      tick();
      cpu_r_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (cpu_rd_valid) begin
            got = 1;
            break;
         end
         check({tag, "_wait"}, cpu_wait, 1);
      end
      check({tag, "_rd_valid"}, got, 1);
      check({tag, "_cpu_do"}, cpu_do, e);
      check({tag, "_wait_low"}, cpu_wait, 0);
      tick();
      check({tag, "_pulse"}, cpu_rd_valid, 0);
      check({tag, "_hold"}, cpu_do, e);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      int n, bad, model_cnt;
      logic ph;
      for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h5A;
      preload = 1'b1;
      repeat (2) tick();
      preload = 1'b0;
      check_reset_outs("reset");
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Scenario 1: ten back-to-back video lookups of preloaded data
      for (int i = 0; i < 10; i++) begin
         vid_rd_n = 1'b0;
         vid_a = 8'(i);
         tick();
      end
      vid_rd_n = 1'b1;
      repeat (5) tick();
      check("t1_count", cap_n, 10);
      check("t1_first", cap[0], 8'h5A);
      check("t1_last", cap[9], 8'h53);

      // Scenario 2: posted write then read of the same address
      do_write(8'h10, 8'hC3);
      do_read(8'h10, 8'hC3, "t2");

      // Scenario 3: video hogs the port, queue fills and the fifth write drops
      vid_rd_n = 1'b0;
      vid_a = 8'h40;
      tick();
      model_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         cpu_w_n = 1'b0;
         cpu_a = 8'h50 + 8'(k);
         cpu_di = 8'hA0 + 8'(k);
         @(negedge clk);
         check("t3_wait", cpu_wait, (model_cnt >= DEPTH) ? 1 : 0);
         check("t3_nodrop", wr_drop, 0);
         if (model_cnt < DEPTH) begin
            exp_mem[cpu_a] = cpu_di;
            model_cnt++;
         end
         @(posedge clk);
         #1;
      end
      cpu_w_n = 1'b1;
      @(negedge clk);
      check("t3_drop", wr_drop, 1);
      check("t3_stalled", mem[8'h50], 8'h0A);
      tick();
      check("t3_drop_pulse", wr_drop, 0);
      vid_rd_n = 1'b1;
      repeat (8) tick();
      check("t3_wait_clear", cpu_wait, 0);
      for (int k = 0; k < 5; k++) check("t3_mem", mem[8'h50 + k], exp_mem[8'h50 + k]);
      check("t3_dropped_addr", mem[8'h54], 8'h0E);

      // Scenario 4: clear sweep with a write posted mid-sweep
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      n = 0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (!clr_busy) break;
         n++;
         if (n == 100) begin
            cpu_w_n = 1'b0;
            cpu_a = 8'h20;
            cpu_di = 8'h77;
         end else begin
            cpu_w_n = 1'b1;
         end
      end
      cpu_w_n = 1'b1;
      check("t4_busy_cycles", n, 256);
      repeat (4) tick();
      for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
      exp_mem[8'h20] = 8'h77;
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] != exp_mem[i]) bad++;
      check("t4_mem_bad", bad, 0);
      check("t4_mem_20", mem[8'h20], 8'h77);
      check("t4_mem_ff", mem[8'hFF], 8'h00);

      // Scenario 5: video on alternate cycles halves the sweep rate
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      vid_a = 8'h31;
      ph = 1'b0;
      vid_rd_n = ph;
      n = 0;
      for (int c = 0; c < 1200; c++) begin
         @(negedge clk);
         if (!clr_busy) break;
         n++;
         @(posedge clk);
         #1;
         ph = ~ph;
         vid_rd_n = ph;
      end
      vid_rd_n = 1'b1;
      check("t5_busy_cycles", n, 512);
      for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
      repeat (4) tick();

      // Scenario 6: reset mid-sweep and mid-read
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      repeat (5) tick();
      check("t6_sweeping", clr_busy, 1);
      #2 reset_n = 1'b0;
      #1 check_reset_outs("t6_sweep");
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("t6_idle_busy", clr_busy, 0);
      cpu_r_n = 1'b0;
      cpu_a = 8'h10;
      tick();
      cpu_r_n = 1'b1;
      repeat (3) tick();
      check("t6_reading", cpu_wait, 1);
      #2 reset_n = 1'b0;
      #1 check_reset_outs("t6_read");
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("t6_queue_empty", cpu_wait, 0);
      do_write(8'h61, 8'h3C);
      do_read(8'h61, 8'h3C, "t6");
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
